// File: rtl/arb_pkg.sv
// Shared constants, state encoding and round-robin pick helper for rr_dec_arbiter.
package arb_pkg;
  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // First set request bit scanning ptr, ptr+1, ... with natural 3-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/dec3x8_en.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when en is low.
module dec3x8_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] a,
  input  logic             en,
  output logic [N_REQ-1:0] y
);
  for (genvar g = 0; g < N_REQ; g++) begin : g_bit
    assign y[g] = en & (a == IDX_W'(g));
  end
endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one decoded select bus.
// Each tenure is capped at MAX_HOLD cycles and followed by one idle
// turnaround cycle. Optional macro ARB_LOCK_EN adds a lock input that
// suppresses the timeout release while asserted.
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic [7:0]       hold_cnt
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic             vld_q;
  logic [7:0]       hold_q;
  logic             lock_on;

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // Arbitrate in IDLE, track tenure length in GRANT, release on drop or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= GRANT;
            idx_q  <= rr_pick(req, ptr);
            vld_q  <= 1'b1;
            hold_q <= '0;
          end
        end
        GRANT: begin
          if (!req[idx_q] || (hold_q == HOLD_LAST && !lock_on)) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            hold_q <= '0;
            ptr    <= idx_q + IDX_W'(1);
          end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
  assign hold_cnt  = hold_q;

  dec3x8_en u_dec (
    .a  (idx_q),
    .en (vld_q),
    .y  (grant)
  );
endmodule
